// File: rtl/vdp_pkg.sv
// Shared definitions for the VDP CPU bus interface: FSM encoding, default
// synchronizer depth / post-access gap, and the captured-access record.
package vdp_pkg;

   localparam int SYNC_STAGES_DEF = 2;
   localparam int GAP_CYCLES_DEF  = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_HOLD  = 2'd2,
      ST_GAP   = 2'd3
   } vdp_state_t;

   typedef struct packed {
      logic       rd;
      logic       mode;
      logic [7:0] din;
   } vdp_acc_t;

endpackage

// File: rtl/vdp_sync.sv
// Single-bit multi-flop synchronizer; all stages reset to RST_VAL so an
// active-low strobe reads as inactive while the chain refills after reset.
module vdp_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b1
) (
   input  logic pxclk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sr;

   generate
      if (STAGES == 1) begin : g_one
         always_ff @(posedge pxclk or negedge reset_n)
            if (!reset_n) sr <= {STAGES{RST_VAL}};
            else          sr <= d;
      end else begin : g_many
         always_ff @(posedge pxclk or negedge reset_n)
            if (!reset_n) sr <= {STAGES{RST_VAL}};
            else          sr <= {sr[STAGES-2:0], d};
      end
   endgenerate

   assign q = sr[STAGES-1];

endmodule

// File: rtl/vdp_bus_ifce.sv
// Z8S180 bus to VDP bridge: synchronizes the async CPU strobes into pxclk and
// turns each CPU access into exactly one wr_tick/rd_tick, then enforces a gap.
module vdp_bus_ifce
   import vdp_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int GAP_CYCLES  = GAP_CYCLES_DEF
) (
   input  logic       pxclk,
   input  logic       reset_n,
   input  logic       cpu_cs_n,
   input  logic       cpu_rd_n,
   input  logic       cpu_wr_n,
   input  logic       cpu_a0,
   input  logic [7:0] cpu_d_in,
   output logic [7:0] cpu_d_out,
   output logic       cpu_d_oe,
   output logic       wr_tick,
   output logic       rd_tick,
   output logic       mode,
   output logic [7:0] din,
   input  logic [7:0] vdp_dout
);

   localparam int CW = ($clog2(GAP_CYCLES + 1) > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   logic cs_s, rd_s, wr_s;

   vdp_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .pxclk(pxclk), .reset_n(reset_n), .d(cpu_cs_n), .q(cs_s));
   vdp_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_rd (
      .pxclk(pxclk), .reset_n(reset_n), .d(cpu_rd_n), .q(rd_s));
   vdp_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_wr (
      .pxclk(pxclk), .reset_n(reset_n), .d(cpu_wr_n), .q(wr_s));

   vdp_state_t    state, state_nxt;
   vdp_acc_t      acc;
   logic [CW-1:0] gap_cnt;
   logic          cap, drop_rd;

   always_comb begin
      state_nxt = state;
      cap       = 1'b0;
      drop_rd   = 1'b0;
      case (state)
         ST_IDLE:
            if (!cs_s) begin
               if (rd_s != wr_s) begin
                  cap       = 1'b1;
                  state_nxt = ST_ISSUE;
               end else if (!rd_s && !wr_s) begin
                  // Both strobes low is illegal: swallow it without a tick.
                  drop_rd   = 1'b1;
                  state_nxt = ST_HOLD;
               end
            end
         ST_ISSUE: state_nxt = ST_HOLD;
         ST_HOLD:
            if (cs_s || (rd_s && wr_s)) state_nxt = ST_GAP;
         ST_GAP:
            if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge pxclk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         gap_cnt   <= '0;
         acc       <= '0;
         cpu_d_out <= '0;
      end else begin
         state   <= state_nxt;
         gap_cnt <= (state == ST_GAP) ? gap_cnt + 1'b1 : '0;
         if (cap) begin
            acc.rd   <= !rd_s;
            acc.mode <= cpu_a0;
            if (rd_s) acc.din <= cpu_d_in;
         end
         if (drop_rd) acc.rd <= 1'b0;
         if (state == ST_ISSUE && acc.rd) cpu_d_out <= vdp_dout;
      end
   end

   assign mode    = acc.mode;
   assign din     = acc.din;
   assign wr_tick = (state == ST_ISSUE) && !acc.rd;
   assign rd_tick = (state == ST_ISSUE) &&  acc.rd;
   // Raw strobes here so the data bus is dropped the moment the CPU lets go.
   assign cpu_d_oe = acc.rd && (state == ST_HOLD) && !cpu_rd_n && !cpu_cs_n;

endmodule

// File: tb/tb_vdp_bus_ifce.sv
// Directed bench for vdp_bus_ifce: drives CPU cycles at negedge, counts ticks
// per pxclk cycle and checks against hand-computed expectations.
module tb_vdp_bus_ifce;

   logic       pxclk = 1'b0;
   logic       reset_n;
   logic       cpu_cs_n, cpu_rd_n, cpu_wr_n, cpu_a0;
   logic [7:0] cpu_d_in, cpu_d_out, din, vdp_dout;
   logic       cpu_d_oe, wr_tick, rd_tick, mode;

   vdp_bus_ifce dut (
      .pxclk(pxclk), .reset_n(reset_n),
      .cpu_cs_n(cpu_cs_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
      .cpu_a0(cpu_a0), .cpu_d_in(cpu_d_in),
      .cpu_d_out(cpu_d_out), .cpu_d_oe(cpu_d_oe),
      .wr_tick(wr_tick), .rd_tick(rd_tick),
      .mode(mode), .din(din), .vdp_dout(vdp_dout)
   );

   always #20 pxclk = ~pxclk;

   int n_tests = 0;
   int n_fail  = 0;

   int   cyc, wr_cnt, rd_cnt, wr_first, rd_first;
   logic tick_mode, oe_seen, both_seen;
   logic [7:0] tick_din;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clr();
      cyc = 0; wr_cnt = 0; rd_cnt = 0; wr_first = -1; rd_first = -1;
      oe_seen = 1'b0; tick_mode = 1'b0; tick_din = 8'h00;
   endtask

   // Advance n cycles; cycle k is sampled at the negedge after the k-th posedge.
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge pxclk);
         @(negedge pxclk);
         cyc++;
         if (wr_tick && rd_tick) both_seen = 1'b1;
         if (cpu_d_oe) oe_seen = 1'b1;
         if (wr_tick) begin
            wr_cnt++;
            if (wr_first < 0) wr_first = cyc;
            tick_mode = mode;
            tick_din  = din;
         end
         if (rd_tick) begin
            rd_cnt++;
            if (rd_first < 0) rd_first = cyc;
            tick_mode = mode;
         end
      end
   endtask

   task automatic bus_idle();
      cpu_cs_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
   endtask

   initial begin
      both_seen = 1'b0;
      reset_n = 1'b0;
      bus_idle();
      cpu_a0 = 1'b0; cpu_d_in = 8'h00; vdp_dout = 8'h00;
      clr();

      // Reset state
      @(negedge pxclk);
      chk("rst_wr_tick", wr_tick, 0);
      chk("rst_rd_tick", rd_tick, 0);
      chk("rst_mode", mode, 0);
      chk("rst_din", din, 0);
      chk("rst_d_out", cpu_d_out, 0);
      chk("rst_d_oe", cpu_d_oe, 0);
      reset_n = 1'b1;
      run(3);

      // Single write, strobe held 8 clk
      clr();
      cpu_a0 = 1'b1; cpu_d_in = 8'h81; cpu_cs_n = 1'b0; cpu_wr_n = 1'b0;
      run(8);
      chk("wr_cnt", wr_cnt, 1);
      chk("wr_latency", wr_first, 3);
      chk("wr_no_rd", rd_cnt, 0);
      chk("wr_mode", tick_mode, 1);
      chk("wr_din", tick_din, 8'h81);
      bus_idle(); cpu_d_in = 8'h00;
      run(6);
      chk("wr_mode_hold", mode, 1);
      chk("wr_din_hold", din, 8'h81);

      // Single read, strobe held 8 clk
      clr();
      vdp_dout = 8'h5A; cpu_a0 = 1'b0; cpu_cs_n = 1'b0; cpu_rd_n = 1'b0;
      run(8);
      chk("rd_cnt", rd_cnt, 1);
      chk("rd_latency", rd_first, 3);
      chk("rd_no_wr", wr_cnt, 0);
      chk("rd_mode", tick_mode, 0);
      chk("rd_d_out", cpu_d_out, 8'h5A);
      chk("rd_oe_held", cpu_d_oe, 1);
      cpu_rd_n = 1'b1;
      #1;
      chk("rd_oe_release", cpu_d_oe, 0);
      cpu_cs_n = 1'b1; vdp_dout = 8'h33;
      run(6);
      chk("rd_d_out_hold", cpu_d_out, 8'h5A);

      // Back-to-back writes with a 1 clk strobe gap
      clr();
      cpu_a0 = 1'b0; cpu_d_in = 8'h11; cpu_cs_n = 1'b0; cpu_wr_n = 1'b0;
      run(5);
      chk("b2b_first_cnt", wr_cnt, 1);
      clr();
      cpu_wr_n = 1'b1;
      run(1);
      cpu_wr_n = 1'b0; cpu_d_in = 8'h22;
      run(9);
      chk("b2b_second_cnt", wr_cnt, 1);
      chk("b2b_second_pos", wr_first, 6);
      chk("b2b_second_din", tick_din, 8'h22);
      bus_idle();
      run(6);

      // rd_n and wr_n low together
      clr();
      cpu_cs_n = 1'b0; cpu_rd_n = 1'b0; cpu_wr_n = 1'b0;
      run(6);
      chk("both_no_wr", wr_cnt, 0);
      chk("both_no_rd", rd_cnt, 0);
      chk("both_no_oe", oe_seen, 0);
      bus_idle();
      run(5);
      clr();
      cpu_a0 = 1'b1; cpu_d_in = 8'hC3; cpu_cs_n = 1'b0; cpu_wr_n = 1'b0;
      run(6);
      chk("both_after_pos", wr_first, 3);
      chk("both_after_din", tick_din, 8'hC3);
      bus_idle();
      run(6);

      // Reset pulse during HOLD of a read
      clr();
      vdp_dout = 8'hA5; cpu_a0 = 1'b0; cpu_cs_n = 1'b0; cpu_rd_n = 1'b0;
      run(6);
      chk("rst_rd_cnt", rd_cnt, 1);
      chk("rst_rd_oe_pre", cpu_d_oe, 1);
      reset_n = 1'b0;
      #1;
      chk("rst_rd_oe_now", cpu_d_oe, 0);
      chk("rst_rd_d_out", cpu_d_out, 0);
      @(posedge pxclk);
      @(negedge pxclk);
      reset_n = 1'b1;
      clr();
      run(8);
      chk("rst_new_rd_cnt", rd_cnt, 1);
      chk("rst_new_rd_pos", rd_first, 3);
      chk("rst_new_d_out", cpu_d_out, 8'hA5);
      bus_idle();
      run(6);

      // Sub-cycle glitch that no posedge samples
      clr();
      cpu_cs_n = 1'b0; cpu_wr_n = 1'b0;
      #5;
      bus_idle();
      run(6);
      chk("glitch_no_wr", wr_cnt, 0);
      chk("glitch_no_rd", rd_cnt, 0);
      clr();
      cpu_a0 = 1'b0; cpu_d_in = 8'h5E; cpu_cs_n = 1'b0; cpu_wr_n = 1'b0;
      run(6);
      chk("glitch_next_pos", wr_first, 3);
      chk("glitch_next_din", tick_din, 8'h5E);
      bus_idle();
      run(6);

      chk("ticks_exclusive", both_seen, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
